// File: rtl/secded_ecc_pipe.sv
// rtl/secded_ecc_pipe.sv - 2-stage pipelined extended-Hamming SECDED encoder/decoder
// Per-transaction encode/decode, valid/ready on both sides, saturating error counters.
module secded_ecc_pipe #(
  parameter int  DATA_WIDTH = 8,
  parameter int  CNT_WIDTH  = 16,
  localparam int P  = (DATA_WIDTH <= 4)  ? 3 :
                      (DATA_WIDTH <= 11) ? 4 :
                      (DATA_WIDTH <= 26) ? 5 :
                      (DATA_WIDTH <= 57) ? 6 : 7,
  localparam int CW = DATA_WIDTH + P + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CW-1:0]         in_codeword,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_mode,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CW-1:0]         out_codeword,
  output logic [P-1:0]          out_syndrome,
  output logic                  err_corr,
  output logic                  err_uncorr,
  input  logic                  cnt_clear,
  output logic [CNT_WIDTH-1:0]  corr_count,
  output logic [CNT_WIDTH-1:0]  uncorr_count
);

  // XOR of the Hamming positions of every set bit; zero for a clean codeword.
  function automatic logic [P-1:0] syn_of(input logic [CW-1:0] cw);
    logic [P-1:0] s;
    s = '0;
    for (int pos = 1; pos < CW; pos++) begin
      if (cw[pos-1]) s = s ^ P'(pos);
    end
    return s;
  endfunction

  function automatic logic [CW-1:0] encode(input logic [DATA_WIDTH-1:0] d);
    logic [CW-1:0] cw;
    logic [P-1:0]  s;
    int            k;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos-1] = d[k];
        k++;
      end
    end
    // With parity slots still zero, the syndrome equals the required parity bits.
    s = syn_of(cw);
    for (int j = 0; j < P; j++) cw[(1 << j) - 1] = s[j];
    cw[CW-1] = ^cw[CW-2:0];
    return cw;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extract(input logic [CW-1:0] cw);
    logic [DATA_WIDTH-1:0] d;
    int                    k;
    d = '0;
    k = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k] = cw[pos-1];
        k++;
      end
    end
    return d;
  endfunction

  logic                  s1_valid_q, s1_mode_q, s1_ovp_q;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic [CW-1:0]         s1_cw_q;
  logic [P-1:0]          s1_syn_q, s1_syn_d;
  logic                  s1_ovp_d;

  logic                  s2_valid_q, s2_mode_q, s2_corr_q, s2_uncorr_q;
  logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
  logic [CW-1:0]         s2_cw_q, s2_cw_d;
  logic [P-1:0]          s2_syn_q, s2_syn_d;
  logic                  s2_corr_d, s2_uncorr_d;

  logic [CNT_WIDTH-1:0]  corr_cnt_q, corr_cnt_d, uncorr_cnt_q, uncorr_cnt_d;
  logic                  advance, out_hs;

  assign advance  = !s2_valid_q || out_ready;
  assign in_ready = advance;
  assign out_hs   = s2_valid_q && out_ready;

  assign s1_syn_d = in_mode ? syn_of(in_codeword) : '0;
  assign s1_ovp_d = in_mode & (^in_codeword);

  always_comb begin
    s2_cw_d     = s1_cw_q;
    s2_syn_d    = s1_syn_q;
    s2_corr_d   = 1'b0;
    s2_uncorr_d = 1'b0;
    if (!s1_mode_q) begin
      s2_cw_d  = encode(s1_data_q);
      s2_syn_d = '0;
    end else if (s1_syn_q == '0) begin
      if (s1_ovp_q) begin
        s2_cw_d[CW-1] = ~s1_cw_q[CW-1];
        s2_corr_d     = 1'b1;
      end
    end else if (s1_ovp_q && (int'(s1_syn_q) <= CW - 1)) begin
      for (int i = 0; i < CW - 1; i++) begin
        if (s1_syn_q == P'(i + 1)) s2_cw_d[i] = ~s1_cw_q[i];
      end
      s2_corr_d = 1'b1;
    end else begin
      // Double error, or a syndrome pointing past the codeword: pass raw through.
      s2_uncorr_d = 1'b1;
    end
    s2_data_d = s1_mode_q ? extract(s2_cw_d) : s1_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_data_q   <= '0;
      s1_cw_q     <= '0;
      s1_syn_q    <= '0;
      s1_ovp_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_mode_q   <= 1'b0;
      s2_data_q   <= '0;
      s2_cw_q     <= '0;
      s2_syn_q    <= '0;
      s2_corr_q   <= 1'b0;
      s2_uncorr_q <= 1'b0;
    end else if (advance) begin
      s1_valid_q  <= in_valid;
      s1_mode_q   <= in_mode;
      s1_data_q   <= in_data;
      s1_cw_q     <= in_codeword;
      s1_syn_q    <= s1_syn_d;
      s1_ovp_q    <= s1_ovp_d;
      s2_valid_q  <= s1_valid_q;
      s2_mode_q   <= s1_mode_q;
      s2_data_q   <= s2_data_d;
      s2_cw_q     <= s2_cw_d;
      s2_syn_q    <= s2_syn_d;
      s2_corr_q   <= s2_corr_d;
      s2_uncorr_q <= s2_uncorr_d;
    end
  end

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clear) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else begin
      if (out_hs && s2_corr_q && (corr_cnt_q != '1))
        corr_cnt_d = corr_cnt_q + CNT_WIDTH'(1);
      if (out_hs && s2_uncorr_q && (uncorr_cnt_q != '1))
        uncorr_cnt_d = uncorr_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_mode     = s2_mode_q;
  assign out_data     = s2_data_q;
  assign out_codeword = s2_cw_q;
  assign out_syndrome = s2_syn_q;
  assign err_corr     = s2_corr_q;
  assign err_uncorr   = s2_uncorr_q;
  assign corr_count   = corr_cnt_q;
  assign uncorr_count = uncorr_cnt_q;

endmodule
